// File: rtl/wb_stage_r.sv
// Writeback stage: sequences up to two register-file writes per instruction.
// Optional WB_BYPASS_EN adds combinational forwarding of the pending write.
module wb_stage_r #(
    parameter int DW = 16,
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] instruction_in,
    input  logic          condition_in,
    input  logic          LS_in,
    input  logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] writeback_in,
    input  logic [DW-1:0] alu_in,
    output logic          rf_we,
    output logic [3:0]    rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          pc_load,
    output logic [DW-1:0] pc_data,
    output logic          stall_out
`ifdef WB_BYPASS_EN
    ,
    output logic          fwd_valid,
    output logic [3:0]    fwd_addr,
    output logic [DW-1:0] fwd_data
`endif
);

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    localparam logic [3:0] PC_REG = 4'd15;
    localparam logic [3:0] LR_REG = 4'd14;

    state_t state, nxt_state;

    logic [3:0]    rd, rn, opc;
    logic [1:0]    cls;
    logic          wbit, lbit, link;

    logic          w1_v, w2_v;
    logic [3:0]    w1_a, w2_a;
    logic [DW-1:0] w1_d, w2_d;

    logic [3:0]    pend_a;
    logic [DW-1:0] pend_d;

    logic          nxt_v;
    logic [3:0]    nxt_a;
    logic [DW-1:0] nxt_d;
    logic          nxt_pc;

    logic          unused_ins;

    assign rd   = instruction_in[15:12];
    assign rn   = instruction_in[19:16];
    assign lbit = instruction_in[20];
    assign opc  = instruction_in[24:21];
    assign link = instruction_in[24];
    assign cls  = instruction_in[27:26];
    // Base writeback to the PC is meaningless, so it is suppressed.
    assign wbit = instruction_in[21] & (rn != PC_REG);

    assign unused_ins = ^{instruction_in[IW-1:28],
                          instruction_in[25],
                          instruction_in[11:0]};

    always_comb begin
        w1_v = 1'b0;
        w1_a = rd;
        w1_d = alu_in;
        w2_v = 1'b0;
        w2_a = rn;
        w2_d = writeback_in;
        unique case (1'b1)
            LS_in && lbit: begin
                w1_v = 1'b1;
                w1_d = mem_data_in;
                w2_v = wbit;
            end
            LS_in && !lbit: begin
                w1_v = wbit;
                w1_a = rn;
                w1_d = writeback_in;
            end
            !LS_in && (cls == 2'b00): begin
                w1_v = (opc[3:2] != 2'b10);
            end
            !LS_in && (cls == 2'b10): begin
                w1_v = link;
                w1_a = LR_REG;
            end
            default: ;
        endcase
    end

    always_comb begin
        nxt_state = state;
        nxt_v     = 1'b0;
        nxt_a     = w1_a;
        nxt_d     = w1_d;
        unique case (state)
            IDLE: begin
                if (condition_in) begin
                    nxt_v = w1_v;
                    if (w2_v) begin
                        nxt_state = PEND;
                    end
                end
            end
            PEND: begin
                nxt_v     = 1'b1;
                nxt_a     = pend_a;
                nxt_d     = pend_d;
                nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign nxt_pc = (nxt_a == PC_REG);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_a <= '0;
            pend_d <= '0;
        end else if (state == IDLE && condition_in && w2_v) begin
            pend_a <= w2_a;
            pend_d <= w2_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            pc_load  <= 1'b0;
            pc_data  <= '0;
        end else begin
            rf_we   <= nxt_v && !nxt_pc;
            pc_load <= nxt_v && nxt_pc;
            if (nxt_v && !nxt_pc) begin
                rf_waddr <= nxt_a;
                rf_wdata <= nxt_d;
            end
            if (nxt_v && nxt_pc) begin
                pc_data <= nxt_d;
            end
        end
    end

    assign stall_out = (state == PEND);

`ifdef WB_BYPASS_EN
    assign fwd_valid = reset & nxt_v;
    assign fwd_addr  = nxt_a;
    assign fwd_data  = nxt_d;
`endif

endmodule

// File: tb/tb_wb_stage_r.sv
// Directed bench for wb_stage_r: queue-of-writes model plus literal checks.
module tb_wb_stage_r;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction_in = '0;
    logic        condition_in = 1'b0;
    logic        LS_in = 1'b0;
    logic [15:0] mem_data_in = '0;
    logic [15:0] writeback_in = '0;
    logic [15:0] alu_in = '0;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        pc_load;
    logic [15:0] pc_data;
    logic        stall_out;

    int checks = 0;
    int errors = 0;

    wb_stage_r #(.DW(16), .IW(32)) dut (
        .clk(clk),
        .reset(reset),
        .instruction_in(instruction_in),
        .condition_in(condition_in),
        .LS_in(LS_in),
        .mem_data_in(mem_data_in),
        .writeback_in(writeback_in),
        .alu_in(alu_in),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .pc_load(pc_load),
        .pc_data(pc_data),
        .stall_out(stall_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         mq[$];
    wr_t         nw[$];
    logic        exp_we = 1'b0;
    logic        exp_pc = 1'b0;
    logic        exp_stall = 1'b0;
    logic [3:0]  exp_a = '0;
    logic [15:0] exp_d = '0;

    function automatic wr_t mkw(input logic [3:0] a, input logic [15:0] d);
        wr_t t;
        t.a = a;
        t.d = d;
        return t;
    endfunction

    // Model: each instruction yields a list of writes; one retires per cycle.
    always @(posedge clk or negedge reset) begin
        wr_t  cur;
        logic have;
        logic [3:0] m_rd, m_rn, m_opc;
        logic m_w, m_l;
        logic [1:0] m_cls;
        have = 1'b0;
        cur = '0;
        if (!reset) begin
            mq.delete();
        end else if (mq.size() > 0) begin
            cur = mq.pop_front();
            have = 1'b1;
        end else if (condition_in) begin
            nw.delete();
            m_rd  = instruction_in[15:12];
            m_rn  = instruction_in[19:16];
            m_l   = instruction_in[20];
            m_w   = instruction_in[21] && m_rn != 4'd15;
            m_opc = instruction_in[24:21];
            m_cls = instruction_in[27:26];
            if (LS_in) begin
                if (m_l) begin
                    nw.push_back(mkw(m_rd, mem_data_in));
                    if (m_w) nw.push_back(mkw(m_rn, writeback_in));
                end else if (m_w) begin
                    nw.push_back(mkw(m_rn, writeback_in));
                end
            end else if (m_cls == 2'b00) begin
                if (m_opc < 4'd8 || m_opc > 4'd11)
                    nw.push_back(mkw(m_rd, alu_in));
            end else if (m_cls == 2'b10 && instruction_in[24]) begin
                nw.push_back(mkw(4'd14, alu_in));
            end
            if (nw.size() > 0) begin
                cur = nw.pop_front();
                have = 1'b1;
                foreach (nw[i]) mq.push_back(nw[i]);
            end
        end
        exp_we    = have && cur.a != 4'd15;
        exp_pc    = have && cur.a == 4'd15;
        exp_a     = cur.a;
        exp_d     = cur.d;
        exp_stall = mq.size() > 0;
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h",
                     name, $time, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("rf_we", 32'(rf_we), 32'(exp_we));
            chk("pc_load", 32'(pc_load), 32'(exp_pc));
            chk("stall_out", 32'(stall_out), 32'(exp_stall));
            if (exp_we) begin
                chk("rf_waddr", 32'(rf_waddr), 32'(exp_a));
                chk("rf_wdata", 32'(rf_wdata), 32'(exp_d));
            end
            if (exp_pc) chk("pc_data", 32'(pc_data), 32'(exp_d));
            if (!reset) begin
                chk("rst_waddr", 32'(rf_waddr), 32'h0);
                chk("rst_wdata", 32'(rf_wdata), 32'h0);
                chk("rst_pc_data", 32'(pc_data), 32'h0);
            end
        end
    end

    function automatic logic [31:0] dp(input logic [3:0] opc,
                                       input logic [3:0] rd,
                                       input logic [3:0] rn);
        return {4'hE, 2'b00, 1'b0, opc, 1'b0, rn, rd, 12'h000};
    endfunction

    function automatic logic [31:0] ls(input logic l, input logic w,
                                       input logic [3:0] rn,
                                       input logic [3:0] rd);
        return {4'hE, 2'b01, 1'b0, 3'b110, w, l, rn, rd, 12'h000};
    endfunction

    function automatic logic [31:0] br(input logic lk);
        return {4'hE, 2'b10, 1'b1, lk, 24'h000123};
    endfunction

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic set(input logic [31:0] ins, input logic c,
                       input logic l, input logic [15:0] m,
                       input logic [15:0] w, input logic [15:0] a);
        instruction_in = ins;
        condition_in   = c;
        LS_in          = l;
        mem_data_in    = m;
        writeback_in   = w;
        alu_in         = a;
    endtask

    task automatic idle();
        set(dp(4'b0100, 4'd1, 4'd1), 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            tick();
            set($urandom, 1'b1, 1'($urandom), 16'($urandom),
                16'($urandom), 16'($urandom));
        end
        tick();
        chk("lit_rst_we", 32'(rf_we), 32'h0);
        chk("lit_rst_pc", 32'(pc_load), 32'h0);
        reset = 1'b1;
        idle();
        tick();
        tick();
        chk("lit_idle_we", 32'(rf_we), 32'h0);
        chk("lit_idle_stall", 32'(stall_out), 32'h0);

        set(dp(4'b0100, 4'd9, 4'd1), 1'b1, 1'b0, 16'h0, 16'h0, 16'h0013);
        tick();
        chk("lit_add_we", 32'(rf_we), 32'h1);
        chk("lit_add_addr", 32'(rf_waddr), 32'h9);
        chk("lit_add_data", 32'(rf_wdata), 32'h0013);
        idle();
        tick();
        chk("lit_add_drop", 32'(rf_we), 32'h0);

        set(dp(4'b1010, 4'd3, 4'd1), 1'b1, 1'b0, 16'h0, 16'h0, 16'h1111);
        tick();
        chk("lit_cmp_we", 32'(rf_we), 32'h0);
        chk("lit_cmp_pc", 32'(pc_load), 32'h0);
        set(dp(4'b0100, 4'd3, 4'd1), 1'b0, 1'b0, 16'h0, 16'h0, 16'h2222);
        tick();
        chk("lit_nocond_we", 32'(rf_we), 32'h0);

        set(ls(1'b1, 1'b1, 4'd4, 4'd2), 1'b1, 1'b1, 16'hBEEF, 16'h0024, 16'h0);
        tick();
        chk("lit_ldr1_addr", 32'(rf_waddr), 32'h2);
        chk("lit_ldr1_data", 32'(rf_wdata), 32'hBEEF);
        chk("lit_ldr1_stall", 32'(stall_out), 32'h1);
        set(dp(4'b0100, 4'd7, 4'd0), 1'b1, 1'b0, 16'h0, 16'h0, 16'h7777);
        tick();
        chk("lit_ldr2_addr", 32'(rf_waddr), 32'h4);
        chk("lit_ldr2_data", 32'(rf_wdata), 32'h0024);
        chk("lit_ldr2_stall", 32'(stall_out), 32'h0);
        idle();
        tick();
        chk("lit_stall_ignored", 32'(rf_we), 32'h0);

        set(dp(4'b1101, 4'd15, 4'd0), 1'b1, 1'b0, 16'h0, 16'h0, 16'h0040);
        tick();
        chk("lit_mov_pc", 32'(pc_load), 32'h1);
        chk("lit_mov_pcdata", 32'(pc_data), 32'h0040);
        chk("lit_mov_we", 32'(rf_we), 32'h0);
        set(br(1'b1), 1'b1, 1'b0, 16'h0, 16'h0, 16'h000C);
        tick();
        chk("lit_bl_addr", 32'(rf_waddr), 32'hE);
        chk("lit_bl_data", 32'(rf_wdata), 32'h000C);
        chk("lit_bl_pc", 32'(pc_load), 32'h0);
        set(br(1'b0), 1'b1, 1'b0, 16'h0, 16'h0, 16'h5555);
        tick();
        chk("lit_b_we", 32'(rf_we), 32'h0);

        set(ls(1'b1, 1'b1, 4'd6, 4'd6), 1'b1, 1'b1, 16'hA1A1, 16'hB2B2, 16'h0);
        tick();
        chk("lit_same1", 32'(rf_wdata), 32'hA1A1);
        idle();
        tick();
        chk("lit_same2", 32'(rf_wdata), 32'hB2B2);
        set(ls(1'b0, 1'b1, 4'd8, 4'd1), 1'b1, 1'b1, 16'h0, 16'h0808, 16'h0);
        tick();
        chk("lit_str_addr", 32'(rf_waddr), 32'h8);
        chk("lit_str_stall", 32'(stall_out), 32'h0);
        set(ls(1'b0, 1'b0, 4'd8, 4'd1), 1'b1, 1'b1, 16'h0, 16'h0909, 16'h0);
        tick();
        chk("lit_str_now", 32'(rf_we), 32'h0);
        set(ls(1'b1, 1'b1, 4'd15, 4'd3), 1'b1, 1'b1, 16'h3333, 16'h4444, 16'h0);
        tick();
        chk("lit_rn15_addr", 32'(rf_waddr), 32'h3);
        chk("lit_rn15_stall", 32'(stall_out), 32'h0);
        set(ls(1'b1, 1'b0, 4'd2, 4'd15), 1'b1, 1'b1, 16'h0100, 16'h0, 16'h0);
        tick();
        chk("lit_ldpc", 32'(pc_data), 32'h0100);

        set(ls(1'b1, 1'b1, 4'd4, 4'd2), 1'b1, 1'b1, 16'hBEEF, 16'h0024, 16'h0);
        tick();
        chk("lit_pend_stall", 32'(stall_out), 32'h1);
        reset = 1'b0;
        tick();
        chk("lit_rstpend_we", 32'(rf_we), 32'h0);
        chk("lit_rstpend_stall", 32'(stall_out), 32'h0);
        reset = 1'b1;
        set(dp(4'b0100, 4'd5, 4'd0), 1'b1, 1'b0, 16'h0, 16'h0, 16'h0055);
        tick();
        chk("lit_post_addr", 32'(rf_waddr), 32'h5);
        chk("lit_post_data", 32'(rf_wdata), 32'h0055);
        idle();
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
